etapa_writeback: RTL and testbench

- MEM/WB pipeline register and write-back stage of the MIPS datapath.
- Sits directly upstream of the 32x32 register bank and drives its write port (wrData, wAddr, regWriteFlag).
- Selects the result (ALU, load data, PC+4) and extracts/extends load data.
- Holds the pipeline until load data returns, and exposes a bypass path to the forwarding unit.

---
 rtl/mips_pkg.sv | 33 +++
 rtl/extractor_carga.sv | 29 ++
 rtl/etapa_writeback.sv | 125 ++++++++++++
 tb/tb_etapa_writeback.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: result select, load types,
// write-back state encoding and the load misalignment rule.
package mips_pkg;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [2:0] LD_W  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_HU = 3'b010;
    localparam logic [2:0] LD_B  = 3'b011;
    localparam logic [2:0] LD_BU = 3'b100;

    typedef logic [1:0] wbState_t;

    localparam wbState_t EMPTY    = 2'b00;
    localparam wbState_t COMMIT   = 2'b01;
    localparam wbState_t WAIT_MEM = 2'b10;

    // Unknown load types behave as LW, including the alignment rule.
    function automatic logic isMisaligned(
        input logic [2:0] loadType,
        input logic [1:0] byteOff
    );
        case (loadType)
            LD_H, LD_HU: return byteOff[0];
            LD_B, LD_BU: return 1'b0;
            default:     return byteOff != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/extractor_carga.sv
// Load data extraction: selects the half/byte addressed by
// byteOff, sign/zero extends it and flags misaligned accesses.
module extractor_carga
    import mips_pkg::*;
(
    input  logic [2:0]  loadType,
    input  logic [1:0]  byteOff,
    input  logic [31:0] word,
    output logic [31:0] data,
    output logic        misalign
);

    logic [15:0] half;
    logic [7:0]  byteVal;

    always_comb begin
        half    = byteOff[1] ? word[31:16] : word[15:0];
        byteVal = word[{byteOff, 3'b000} +: 8];
        case (loadType)
            LD_H:    data = {{16{half[15]}}, half};
            LD_HU:   data = {16'h0000, half};
            LD_B:    data = {{24{byteVal[7]}}, byteVal};
            LD_BU:   data = {24'h000000, byteVal};
            default: data = word;
        endcase
        misalign = isMisaligned(loadType, byteOff);
    end

endmodule

// File: rtl/etapa_writeback.sv
// MEM/WB register and write-back stage with load wait and bypass.
// Optional WB_RETIRE_COUNT_EN adds a retired-instruction counter.
module etapa_writeback
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inValid,
    input  logic              inRegWrite,
    input  logic [ADDR_W-1:0] inWAddr,
    input  logic [1:0]        inResSel,
    input  logic [2:0]        inLoadType,
    input  logic [1:0]        inByteOff,
    input  logic [DATA_W-1:0] inAluRes,
    input  logic [DATA_W-1:0] inPc4,
    input  logic [DATA_W-1:0] memRdData,
    input  logic              memRdValid,
    input  logic              flush,
    output logic              stallOut,
    output logic [DATA_W-1:0] wrData,
    output logic [ADDR_W-1:0] wAddr,
    output logic              regWriteFlag,
    output logic              misalignErr,
    output logic              fwdValid,
    output logic [ADDR_W-1:0] fwdAddr,
    output logic [DATA_W-1:0] fwdData
`ifdef WB_RETIRE_COUNT_EN
   ,output logic [31:0]       retireCount
`endif
);

    wbState_t          state;
    wbState_t          nextState;
    logic              eRegWrite;
    logic [ADDR_W-1:0] eWAddr;
    logic [1:0]        eResSel;
    logic [2:0]        eLoadType;
    logic [1:0]        eByteOff;
    logic [DATA_W-1:0] eAluRes;
    logic [DATA_W-1:0] ePc4;

    logic [DATA_W-1:0] loadData;
    logic [DATA_W-1:0] result;
    logic              loadMis;
    logic              commitNow;
    logic              live;
    logic              misCommit;

    extractor_carga uExtractor (
        .loadType (eLoadType),
        .byteOff  (eByteOff),
        .word     (memRdData),
        .data     (loadData),
        .misalign (loadMis)
    );

    always_comb begin
        case (eResSel)
            RES_MEM: result = loadData;
            RES_PC4: result = ePc4;
            default: result = eAluRes;
        endcase
    end

    // A flush kills the commit of the held entry in either state.
    assign commitNow = (state == COMMIT)
                     | ((state == WAIT_MEM) & memRdValid);
    assign live      = commitNow & ~flush;
    assign misCommit = live & (state == COMMIT)
                     & (eResSel == RES_MEM) & loadMis;

    assign stallOut     = (state == WAIT_MEM) & ~memRdValid & ~flush;
    assign wrData       = live ? result : '0;
    assign wAddr        = live ? eWAddr : '0;
    assign regWriteFlag = live & eRegWrite
                        & (eWAddr != '0) & ~misCommit;
    assign misalignErr  = misCommit;
    assign fwdValid     = regWriteFlag;
    assign fwdAddr      = wAddr;
    assign fwdData      = wrData;

    always_comb begin
        nextState = COMMIT;
        if (!inValid || flush)
            nextState = EMPTY;
        else if (inResSel == RES_MEM
                 && !isMisaligned(inLoadType, inByteOff))
            nextState = WAIT_MEM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            eRegWrite <= 1'b0;
            eWAddr    <= '0;
            eResSel   <= RES_ALU;
            eLoadType <= LD_W;
            eByteOff  <= 2'b00;
            eAluRes   <= '0;
            ePc4      <= '0;
        end else if (!stallOut) begin
            state     <= nextState;
            eRegWrite <= inRegWrite;
            eWAddr    <= inWAddr;
            eResSel   <= inResSel;
            eLoadType <= inLoadType;
            eByteOff  <= inByteOff;
            eAluRes   <= inAluRes;
            ePc4      <= inPc4;
        end
    end

`ifdef WB_RETIRE_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retireCount <= '0;
        else if (live && !misCommit)
            retireCount <= retireCount + 32'd1;
    end
`endif

endmodule

// File: tb/tb_etapa_writeback.sv
// Scoreboard bench for etapa_writeback: a driver issues random and
// directed instructions, a monitor checks every visible commit.
module tb_etapa_writeback;

    logic        clk;
    logic        rst_n;
    logic        inValid;
    logic        inRegWrite;
    logic [4:0]  inWAddr;
    logic [1:0]  inResSel;
    logic [2:0]  inLoadType;
    logic [1:0]  inByteOff;
    logic [31:0] inAluRes;
    logic [31:0] inPc4;
    logic [31:0] memRdData;
    logic        memRdValid;
    logic        flush;
    logic        stallOut;
    logic [31:0] wrData;
    logic [4:0]  wAddr;
    logic        regWriteFlag;
    logic        misalignErr;
    logic        fwdValid;
    logic [4:0]  fwdAddr;
    logic [31:0] fwdData;
`ifdef WB_RETIRE_COUNT_EN
    logic [31:0] retireCount;
`endif

    etapa_writeback dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inValid      (inValid),
        .inRegWrite   (inRegWrite),
        .inWAddr      (inWAddr),
        .inResSel     (inResSel),
        .inLoadType   (inLoadType),
        .inByteOff    (inByteOff),
        .inAluRes     (inAluRes),
        .inPc4        (inPc4),
        .memRdData    (memRdData),
        .memRdValid   (memRdValid),
        .flush        (flush),
        .stallOut     (stallOut),
        .wrData       (wrData),
        .wAddr        (wAddr),
        .regWriteFlag (regWriteFlag),
        .misalignErr  (misalignErr),
        .fwdValid     (fwdValid),
        .fwdAddr      (fwdAddr),
        .fwdData      (fwdData)
`ifdef WB_RETIRE_COUNT_EN
       ,.retireCount  (retireCount)
`endif
    );

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        we;
        logic        mis;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] expRetire = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", n, act, exp);
        end
    endtask

    function automatic logic refMis(input logic [2:0] lt,
                                    input logic [1:0] off);
        if (lt == 3'd1 || lt == 3'd2) return off % 2 != 0;
        if (lt == 3'd3 || lt == 3'd4) return 1'b0;
        return off != 0;
    endfunction

    function automatic logic [31:0] refLoad(input logic [2:0] lt,
                                            input logic [1:0] off,
                                            input logic [31:0] mem);
        logic [31:0] h;
        logic [31:0] b;
        h = (mem >> (16 * (off / 2))) & 32'h0000_FFFF;
        b = (mem >> (8 * off)) & 32'h0000_00FF;
        case (lt)
            3'd1:    return (h >= 32'h8000) ? h - 32'h0001_0000 : h;
            3'd2:    return h;
            3'd3:    return (b >= 32'h80) ? b - 32'h100 : b;
            3'd4:    return b;
            default: return mem;
        endcase
    endfunction

    // Issue one instruction; returns one cycle after its commit edge
    // (or its capture edge for non-waiting results).
    task automatic issue(input logic rw, input logic [4:0] wa,
                         input logic [1:0] rs, input logic [2:0] lt,
                         input logic [1:0] off, input logic [31:0] alu,
                         input logic [31:0] pc4, input logic [31:0] mem,
                         input int delay);
        exp_t e;
        logic isLoad;
        logic mis;
        isLoad = (rs == 2'd1);
        mis    = isLoad && refMis(lt, off);
        e.addr = wa;
        e.mis  = mis;
        e.we   = rw && wa != 0 && !mis;
        e.data = (rs == 2'd2) ? pc4 : isLoad ? refLoad(lt, off, mem) : alu;
        if (e.we || e.mis) q.push_back(e);
        if (!mis) expRetire = expRetire + 1;
        inValid    = 1'b1;
        inRegWrite = rw;
        inWAddr    = wa;
        inResSel   = rs;
        inLoadType = lt;
        inByteOff  = off;
        inAluRes   = alu;
        inPc4      = pc4;
        #1 chk("stall_idle", {31'd0, stallOut}, 32'd0);
        @(posedge clk);
        #1;
        inValid  = 1'b0;
        inAluRes = $urandom;
        if (isLoad && !mis) begin
            for (int i = 0; i < delay; i++) begin
                #1 chk("stall_wait", {31'd0, stallOut}, 32'd1);
                @(posedge clk);
                #1;
            end
            memRdValid = 1'b1;
            memRdData  = mem;
            #1 chk("stall_ret", {31'd0, stallOut}, 32'd0);
            @(posedge clk);
            #1;
            memRdValid = 1'b0;
            memRdData  = $urandom;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (regWriteFlag || misalignErr || fwdValid)) begin
                if (q.size() == 0) begin
                    chk("unexpected_commit",
                        {wAddr, 25'd0, regWriteFlag, misalignErr}, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("we", {31'd0, regWriteFlag}, {31'd0, e.we});
                    chk("mis", {31'd0, misalignErr}, {31'd0, e.mis});
                    chk("waddr", {27'd0, wAddr}, {27'd0, e.addr});
                    if (!e.mis) chk("wrdata", wrData, e.data);
                    chk("fwdvalid", {31'd0, fwdValid}, {31'd0, e.we});
                    chk("fwdaddr", {27'd0, fwdAddr}, {27'd0, e.addr});
                    if (!e.mis) chk("fwddata", fwdData, e.data);
                end
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        inValid    = 1'b0;
        inRegWrite = 1'b0;
        inWAddr    = 5'd0;
        inResSel   = 2'd0;
        inLoadType = 3'd0;
        inByteOff  = 2'd0;
        inAluRes   = 32'd0;
        inPc4      = 32'd0;
        memRdData  = 32'd0;
        memRdValid = 1'b0;
        flush      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", {31'd0, stallOut}, 32'd0);
        chk("rst_we", {31'd0, regWriteFlag}, 32'd0);
        chk("rst_wrdata", wrData, 32'd0);
        chk("rst_outs", {wAddr, fwdAddr, misalignErr, fwdValid},
            32'd0);
        chk("rst_fwddata", fwdData, 32'd0);
`ifdef WB_RETIRE_COUNT_EN
        chk("rst_retire", retireCount, 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(1, 5'd8, 2'd0, 3'd0, 2'd0, 32'h1234_5678, 32'd0, 32'd0, 0);
        issue(1, 5'd9, 2'd1, 3'd3, 2'd3, 32'd0, 32'd0, 32'h80FF_0000, 3);
        issue(1, 5'd10, 2'd1, 3'd2, 2'd2, 32'd0, 32'd0, 32'hBEEF_1234, 0);
        issue(1, 5'd11, 2'd1, 3'd1, 2'd1, 32'd0, 32'd0, 32'hBEEF_1234, 0);
        issue(1, 5'd31, 2'd2, 3'd0, 2'd0, 32'd7, 32'h0040_0010, 32'd0, 0);
        issue(1, 5'd0, 2'd2, 3'd0, 2'd0, 32'd7, 32'h0040_0010, 32'd0, 0);

        // Flush while the held ALU entry commits.
        inValid    = 1'b1;
        inRegWrite = 1'b1;
        inWAddr    = 5'd5;
        inResSel   = 2'd0;
        inAluRes   = 32'hDEAD_0005;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        flush   = 1'b1;
        #1 chk("flush_commit_we", {31'd0, regWriteFlag}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;

        // Flush together with returning load data, then a late valid.
        inValid    = 1'b1;
        inRegWrite = 1'b1;
        inWAddr    = 5'd12;
        inResSel   = 2'd1;
        inLoadType = 3'd0;
        inByteOff  = 2'd0;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        #1 chk("flush_wait_stall", {31'd0, stallOut}, 32'd1);
        memRdValid = 1'b1;
        memRdData  = 32'hCAFE_F00D;
        flush      = 1'b1;
        #1 chk("flush_mem_stall", {31'd0, stallOut}, 32'd0);
        chk("flush_mem_we", {31'd0, regWriteFlag}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        #1 chk("late_valid_we", {31'd0, regWriteFlag}, 32'd0);
        chk("late_valid_stall", {31'd0, stallOut}, 32'd0);
        @(posedge clk);
        #1;
        memRdValid = 1'b0;

        // Reset while a load is waiting for data.
        inValid    = 1'b1;
        inWAddr    = 5'd13;
        inResSel   = 2'd1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        #1 chk("pre_rst_stall", {31'd0, stallOut}, 32'd1);
        rst_n = 1'b0;
        #1 chk("mid_rst_stall", {31'd0, stallOut}, 32'd0);
        chk("mid_rst_we", {31'd0, regWriteFlag}, 32'd0);
        chk("mid_rst_wrdata", wrData, 32'd0);
        chk("mid_rst_outs", {wAddr, fwdAddr, misalignErr, fwdValid},
            32'd0);
        expRetire = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int n = 0; n < 300; n++) begin
            issue($urandom_range(0, 1), 5'($urandom_range(0, 31)),
                  2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), $urandom, $urandom,
                  $urandom, $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", q.size(), 32'd0);
`ifdef WB_RETIRE_COUNT_EN
        chk("retire_count", retireCount, expRetire);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
